// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter, drives the registered-read
// instruction memory, tracks the single in-flight read and buffers returned
// words in a 2-entry queue towards decode.
//
// Handshake (decode side): if_valid/if_instr/if_pc are presented while a word
// sits at the queue head; a transfer happens on any posedge where
// if_valid && if_ready. if_instr/if_pc stay stable while if_valid && !if_ready.
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [15:0] if_pc,
   input  logic        if_ready
);

   logic [15:0] fetch_pc;
   logic        inflight;
   logic [15:0] inflight_pc;

   // Queue head is always entry 0; entry 1 only holds data when count == 2.
   logic [31:0] q0_instr;
   logic [15:0] q0_pc;
   logic [31:0] q1_instr;
   logic [15:0] q1_pc;
   logic [1:0]  count;

   logic        pop;
   logic        push;
   logic        issue;
   logic [1:0]  occ;
   logic [1:0]  occ_after_pop;

   // Handshake and credit decisions for this cycle.
   always_comb begin
      pop           = (count != 2'd0) && if_ready;
      push          = inflight && !redirect_valid;
      occ           = count + {1'b0, inflight};
      occ_after_pop = occ - {1'b0, pop};
      // Only issue when the response is guaranteed a queue slot.
      issue         = !redirect_valid && (occ_after_pop < 2'd2);
   end

   // Program counter and in-flight read tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 16'h0000;
      end else if (redirect_valid) begin
         fetch_pc    <= {redirect_pc[15:2], 2'b00};
         inflight    <= 1'b0;
      end else if (issue) begin
         fetch_pc    <= fetch_pc + 16'd4;
         inflight    <= 1'b1;
         inflight_pc <= fetch_pc;
      end else begin
         // Memory rereads the same word; that result is never pushed.
         inflight    <= 1'b0;
      end
   end

   // Two-entry output queue with simultaneous push/pop support.
   always_ff @(posedge clk) begin
      if (rst) begin
         q0_instr <= 32'h0;
         q0_pc    <= 16'h0;
         q1_instr <= 32'h0;
         q1_pc    <= 16'h0;
         count    <= 2'd0;
      end else if (redirect_valid) begin
         // A concurrent pop is still taken by decode; everything else is dropped.
         count    <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  q0_instr <= imem_instr;
                  q0_pc    <= inflight_pc;
               end else begin
                  q1_instr <= imem_instr;
                  q1_pc    <= inflight_pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               q0_instr <= q1_instr;
               q0_pc    <= q1_pc;
               count    <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  q0_instr <= imem_instr;
                  q0_pc    <= inflight_pc;
               end else begin
                  q0_instr <= q1_instr;
                  q0_pc    <= q1_pc;
                  q1_instr <= imem_instr;
                  q1_pc    <= inflight_pc;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      imem_pc  = fetch_pc;
      if_valid = (count != 2'd0);
      if_instr = q0_instr;
      if_pc    = q0_pc;
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (RESET_PC = 0 and 16'hFFF8),
// each with its own registered-read instruction memory model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;

  logic [15:0] imem_pc0;
  logic [31:0] imem_instr0;
  logic        redir0;
  logic [15:0] rpc0;
  logic        valid0;
  logic [31:0] instr0;
  logic [15:0] pc0;
  logic        ready0;

  logic [15:0] imem_pc1;
  logic [31:0] imem_instr1;
  logic        valid1;
  logic [31:0] instr1;
  logic [15:0] pc1;
  logic        ready1;
  logic        redir1;

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  instr_fetch #(.RESET_PC(16'h0000)) u0 (
    .clk(clk), .rst(rst), .imem_pc(imem_pc0), .imem_instr(imem_instr0),
    .redirect_valid(redir0), .redirect_pc(rpc0),
    .if_valid(valid0), .if_instr(instr0), .if_pc(pc0), .if_ready(ready0)
  );

  instr_fetch #(.RESET_PC(16'hFFF8)) u1 (
    .clk(clk), .rst(rst), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
    .redirect_valid(redir1), .redirect_pc(16'h0000),
    .if_valid(valid1), .if_instr(instr1), .if_pc(pc1), .if_ready(ready1)
  );

  // Memory content: word index tagged with a constant, 2048 words deep.
  function automatic logic [31:0] word_of(input logic [15:0] pc);
    return 32'hA000_0000 | {21'd0, pc[12:2]};
  endfunction

  always @(posedge clk) begin
    imem_instr0 <= word_of(imem_pc0);
    imem_instr1 <= word_of(imem_pc1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with rst = 0).
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check("rst_imem_pc0", {16'h0, imem_pc0}, 32'h0000);
    check("rst_valid0",   {31'h0, valid0},   32'h0);
    check("rst_instr0",   instr0,            32'h0);
    check("rst_pc0",      {16'h0, pc0},      32'h0);
    check("rst_imem_pc1", {16'h0, imem_pc1}, 32'hFFF8);
    check("rst_valid1",   {31'h0, valid1},   32'h0);
    rst = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, {31'h0, valid0}, 32'h1);
    check({tag, "_pc"},    {16'h0, pc0},    {16'h0, pc});
    check({tag, "_instr"}, instr0,          word_of(pc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    redir0 = 1'b0;
    rpc0   = 16'h0;
    ready0 = 1'b1;
    ready1 = 1'b1;
    redir1 = 1'b0;

    // Test 1: streaming from reset, both RESET_PC values.
    do_reset();
    check("t1_c0_imem_pc", {16'h0, imem_pc0}, 32'h0);
    tick(); // cycle 1
    check("t1_c1_valid",   {31'h0, valid0},   32'h0);
    check("t1_c1_imem_pc", {16'h0, imem_pc0}, 32'h4);
    for (int i = 0; i < 5; i++) begin
      logic [15:0] wrap_pc;
      tick(); // cycles 2..6
      expect_head("t1_stream", 16'(4 * i));
      if (i < 4) begin
        wrap_pc = 16'hFFF8 + 16'(4 * i);
        check("t1_wrap_valid", {31'h0, valid1}, 32'h1);
        check("t1_wrap_pc",    {16'h0, pc1},    {16'h0, wrap_pc});
        check("t1_wrap_instr", instr1,          word_of(wrap_pc));
      end
    end

    // Test 2: decode stalls cycles 2..6, then drains back-to-back.
    ready0 = 1'b0;
    do_reset();
    tick(); // cycle 1
    for (int c = 2; c <= 6; c++) begin
      tick();
      expect_head("t2_stall", 16'h0000);
      check("t2_stall_imem_pc", {16'h0, imem_pc0}, 32'h8);
    end
    tick(); // cycle 7
    ready0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_head("t2_drain", 16'(4 * i));
      tick();
    end

    // Test 3: redirect to 0x0103 at cycle 6 with a full queue.
    ready0 = 1'b0;
    do_reset();
    tick(); // cycle 1
    for (int c = 2; c <= 5; c++) tick();
    tick(); // cycle 6
    redir0 = 1'b1;
    rpc0   = 16'h0103;
    expect_head("t3_full", 16'h0000);
    tick(); // cycle 7
    redir0 = 1'b0;
    ready0 = 1'b1;
    check("t3_c7_valid",   {31'h0, valid0},   32'h0);
    check("t3_c7_imem_pc", {16'h0, imem_pc0}, 32'h0100);
    tick(); // cycle 8
    check("t3_c8_valid",   {31'h0, valid0},   32'h0);
    tick(); // cycle 9
    expect_head("t3_target", 16'h0100);
    tick();
    expect_head("t3_next", 16'h0104);

    // Test 4: redirect in the same cycle PC 8 is popped.
    ready0 = 1'b1;
    do_reset();
    tick(); // cycle 1
    tick(); expect_head("t4_pc0", 16'h0000);
    tick(); expect_head("t4_pc4", 16'h0004);
    tick(); // cycle 4
    expect_head("t4_pc8", 16'h0008);
    redir0 = 1'b1;
    rpc0   = 16'h0200;
    tick(); // cycle 5
    redir0 = 1'b0;
    check("t4_c5_valid", {31'h0, valid0}, 32'h0);
    tick();
    check("t4_c6_valid", {31'h0, valid0}, 32'h0);
    tick(); expect_head("t4_target", 16'h0200);
    tick(); expect_head("t4_next",   16'h0204);
    tick(); expect_head("t4_next2",  16'h0208);

    // Test 5: reset together with redirect mid-stream.
    rst    = 1'b1;
    redir0 = 1'b1;
    rpc0   = 16'h0300;
    tick();
    check("t5_valid",   {31'h0, valid0},   32'h0);
    check("t5_imem_pc", {16'h0, imem_pc0}, 32'h0);
    check("t5_pc",      {16'h0, pc0},      32'h0);
    check("t5_instr",   instr0,            32'h0);
    rst    = 1'b0;
    redir0 = 1'b0;
    tick(); // cycle 1
    check("t5_c1_valid", {31'h0, valid0}, 32'h0);
    tick(); expect_head("t5_restart0", 16'h0000);
    tick(); expect_head("t5_restart4", 16'h0004);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
